// File: rtl/ula_sequencial_pkg.sv
// Opcode values and FSM state encoding shared by the sequential ALU,
// the decoder and the combinational ALU.
package ula_sequencial_pkg;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SUBI = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        MUL_ITERA = 2'd1,
        MUL_FINAL = 2'd2
    } estado_t;

endpackage

// File: rtl/ula_sequencial_mult_iter.sv
// Unsigned iterative shift-add multiplier: one partial product per clock, LARGURA clocks.
// fim is high during the last iteration; produto is complete on the following cycle.
module ula_mult_iter #(
    parameter int LARGURA = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   carregar,
    input  logic [LARGURA-1:0]     multiplicando,
    input  logic [LARGURA-1:0]     multiplicador,
    output logic [2*LARGURA-1:0]   produto,
    output logic                   fim
);
    localparam int CW = $clog2(LARGURA);
    localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

    logic [2*LARGURA-1:0] mcand;
    logic [LARGURA-1:0]   mplier;
    logic [CW-1:0]        cnt;
    logic                 ativo;

    assign fim = ativo && (cnt == ULTIMO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            produto <= '0;
            cnt     <= '0;
            ativo   <= 1'b0;
        end else if (carregar) begin
            mcand   <= {{LARGURA{1'b0}}, multiplicando};
            mplier  <= multiplicador;
            produto <= '0;
            cnt     <= '0;
            ativo   <= 1'b1;
        end else if (ativo) begin
            if (mplier[0])
                produto <= produto + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (fim)
                ativo <= 1'b0;
        end
    end

endmodule

// File: rtl/ula_sequencial.sv
// Sequential ALU: single-cycle LOAD/ADD/SUB, iterative MUL (LARGURA+1 cycles busy),
// signed overflow with optional saturation; requests while ocupado are dropped.
module ula_sequencial
    import ula_sequencial_pkg::*;
#(
    parameter int LARGURA = 16,
    parameter bit SATURAR = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [2:0]         opcode,
    input  logic [LARGURA-1:0] valor1,
    input  logic [LARGURA-1:0] valor2,
    output logic [LARGURA-1:0] resultado,
    output logic               executou,
    output logic               overflow,
    output logic               ocupado,
    output logic               opcode_invalido
);
    localparam logic [LARGURA-1:0] MAX_POS = {1'b0, {(LARGURA-1){1'b1}}};
    localparam logic [LARGURA-1:0] MIN_NEG = {1'b1, {(LARGURA-1){1'b0}}};

    estado_t              estado, estado_prox;
    logic                 sinal;
    logic                 carregar, fim;
    logic [LARGURA-1:0]   mag_a, mag_b;
    logic [2*LARGURA-1:0] produto, produto_sinal;
    logic [LARGURA:0]     a_ext, b_ext, soma;
    logic                 ovf_soma, ovf_mul;
    logic [LARGURA-1:0]   res_prox;
    logic                 ovf_prox, exec_prox, inv_prox;

    function automatic logic [LARGURA-1:0] ajustar(input logic [LARGURA-1:0] baixo,
                                                   input logic ovf, input logic negativo);
        if (SATURAR && ovf)
            return negativo ? MIN_NEG : MAX_POS;
        return baixo;
    endfunction

    // -2^(L-1) negates to itself, which is the correct unsigned magnitude
    assign mag_a = valor1[LARGURA-1] ? -valor1 : valor1;
    assign mag_b = valor2[LARGURA-1] ? -valor2 : valor2;

    assign a_ext    = {valor1[LARGURA-1], valor1};
    assign b_ext    = {valor2[LARGURA-1], valor2};
    assign soma     = (opcode == OP_ADD || opcode == OP_ADDI) ? a_ext + b_ext : a_ext - b_ext;
    assign ovf_soma = soma[LARGURA] ^ soma[LARGURA-1];

    assign produto_sinal = sinal ? -produto : produto;
    assign ovf_mul = (|produto_sinal[2*LARGURA-1:LARGURA-1]) &&
                     !(&produto_sinal[2*LARGURA-1:LARGURA-1]);

    assign ocupado = (estado != OCIOSO);

    ula_mult_iter #(.LARGURA(LARGURA)) u_mult (
        .clk           (clk),
        .reset         (reset),
        .carregar      (carregar),
        .multiplicando (mag_a),
        .multiplicador (mag_b),
        .produto       (produto),
        .fim           (fim)
    );

    always_comb begin
        estado_prox = estado;
        carregar    = 1'b0;
        res_prox    = resultado;
        ovf_prox    = overflow;
        exec_prox   = 1'b0;
        inv_prox    = 1'b0;
        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    case (opcode)
                        OP_LOAD: begin
                            res_prox  = valor2;
                            ovf_prox  = 1'b0;
                            exec_prox = 1'b1;
                        end
                        OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                            res_prox  = ajustar(soma[LARGURA-1:0], ovf_soma, soma[LARGURA]);
                            ovf_prox  = ovf_soma;
                            exec_prox = 1'b1;
                        end
                        OP_MUL: begin
                            carregar    = 1'b1;
                            estado_prox = MUL_ITERA;
                        end
                        default: inv_prox = 1'b1;
                    endcase
                end
            end
            MUL_ITERA: begin
                if (fim)
                    estado_prox = MUL_FINAL;
            end
            MUL_FINAL: begin
                res_prox    = ajustar(produto_sinal[LARGURA-1:0], ovf_mul, sinal);
                ovf_prox    = ovf_mul;
                exec_prox   = 1'b1;
                estado_prox = OCIOSO;
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado          <= OCIOSO;
            sinal           <= 1'b0;
            resultado       <= '0;
            overflow        <= 1'b0;
            executou        <= 1'b0;
            opcode_invalido <= 1'b0;
        end else begin
            estado          <= estado_prox;
            resultado       <= res_prox;
            overflow        <= ovf_prox;
            executou        <= exec_prox;
            opcode_invalido <= inv_prox;
            if (carregar)
                sinal <= valor1[LARGURA-1] ^ valor2[LARGURA-1];
        end
    end

endmodule

// File: tb/tb_ula_sequencial.sv
// Directed bench: wrapping and saturating instances share stimulus; outputs sampled on negedge.
module tb_ula_sequencial;
    import ula_sequencial_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [2:0]  opcode;
    logic [15:0] valor1, valor2;

    logic [15:0] res_w, res_s;
    logic        exe_w, exe_s, ovf_w, ovf_s, ocu_w, ocu_s, inv_w, inv_s;

    int erros = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ula_sequencial #(.LARGURA(16), .SATURAR(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .iniciar(iniciar), .opcode(opcode),
        .valor1(valor1), .valor2(valor2), .resultado(res_w), .executou(exe_w),
        .overflow(ovf_w), .ocupado(ocu_w), .opcode_invalido(inv_w)
    );

    ula_sequencial #(.LARGURA(16), .SATURAR(1'b1)) u_sat (
        .clk(clk), .reset(reset), .iniciar(iniciar), .opcode(opcode),
        .valor1(valor1), .valor2(valor2), .resultado(res_s), .executou(exe_s),
        .overflow(ovf_s), .ocupado(ocu_s), .opcode_invalido(inv_s)
    );

    task automatic verificar(input string tag, input int obs, input int esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic enviar(input logic [2:0] op, input int a, input int b);
        iniciar = 1'b1;
        opcode  = op;
        valor1  = 16'(a);
        valor2  = 16'(b);
        @(negedge clk);
        iniciar = 1'b0;
    endtask

    task automatic executar_mul(input int a, input int b, input bit injetar,
                                output int lat, output int ocup);
        lat  = -1;
        ocup = 0;
        enviar(OP_MUL, a, b);
        for (int k = 1; k <= 40; k++) begin
            if (ocu_w) ocup++;
            if (exe_w) begin
                lat = k;
                break;
            end
            if (injetar && k == 5) begin
                iniciar = 1'b1; opcode = OP_ADD; valor1 = 16'd1; valor2 = 16'd1;
            end else begin
                iniciar = 1'b0;
            end
            @(negedge clk);
        end
        iniciar = 1'b0;
    endtask

    int lat, ocup, vistos;

    initial begin
        reset = 1'b1; iniciar = 1'b0; opcode = '0; valor1 = '0; valor2 = '0;
        repeat (2) @(negedge clk);
        verificar("rst_res", s16(res_w), 0);
        verificar("rst_exe", int'(exe_w), 0);
        verificar("rst_ovf", int'(ovf_w), 0);
        verificar("rst_ocu", int'(ocu_w), 0);
        verificar("rst_inv", int'(inv_w), 0);
        reset = 1'b0;
        @(negedge clk);

        // 1. ADD 100,-30
        enviar(OP_ADD, 100, -30);
        verificar("add_exe", int'(exe_w), 1);
        verificar("add_res", s16(res_w), 70);
        verificar("add_ovf", int'(ovf_w), 0);
        verificar("add_ocu", int'(ocu_w), 0);
        @(negedge clk);
        verificar("add_exe_pulso", int'(exe_w), 0);

        // 2. overflow on ADD and SUBI
        enviar(OP_ADD, 32767, 1);
        verificar("addovf_res_w", s16(res_w), -32768);
        verificar("addovf_ovf_w", int'(ovf_w), 1);
        verificar("addovf_res_s", s16(res_s), 32767);
        verificar("addovf_ovf_s", int'(ovf_s), 1);
        enviar(OP_SUBI, -32768, 1);
        verificar("subi_res_s", s16(res_s), -32768);
        verificar("subi_ovf_s", int'(ovf_s), 1);
        verificar("subi_res_w", s16(res_w), 32767);
        enviar(OP_SUB, 10, 25);
        verificar("sub_res", s16(res_w), -15);
        verificar("sub_ovf", int'(ovf_w), 0);

        // 3. MUL -7,6 with an ignored request mid-flight
        executar_mul(-7, 6, 1'b1, lat, ocup);
        verificar("mul_lat", lat, 18);
        verificar("mul_ocup", ocup, 17);
        verificar("mul_res", s16(res_w), -42);
        verificar("mul_ovf", int'(ovf_w), 0);
        verificar("mul_exe_s", int'(exe_s), 1);
        @(negedge clk);
        verificar("mul_pos_exe", int'(exe_w), 0);
        verificar("mul_pos_res", s16(res_w), -42);

        // 4. most-negative operand and wide products
        executar_mul(-32768, -1, 1'b0, lat, ocup);
        verificar("mn1_res_w", s16(res_w), -32768);
        verificar("mn1_ovf_w", int'(ovf_w), 1);
        verificar("mn1_res_s", s16(res_s), 32767);
        verificar("mn1_ovf_s", int'(ovf_s), 1);
        executar_mul(-32768, 1, 1'b0, lat, ocup);
        verificar("mp1_res_w", s16(res_w), -32768);
        verificar("mp1_ovf_w", int'(ovf_w), 0);
        verificar("mp1_res_s", s16(res_s), -32768);
        executar_mul(255, 257, 1'b0, lat, ocup);
        verificar("m255_res_w", s16(res_w), -1);
        verificar("m255_ovf_w", int'(ovf_w), 1);
        verificar("m255_res_s", s16(res_s), 32767);

        // 5. reset during MUL iteration 8
        executar_mul(0, 0, 1'b0, lat, ocup);
        enviar(OP_LOAD, 0, 77);
        enviar(OP_MUL, 300, 300);
        repeat (7) @(negedge clk);
        verificar("prerst_ocu", int'(ocu_w), 1);
        reset = 1'b1;
        #1;
        verificar("rstmul_res", s16(res_w), 0);
        verificar("rstmul_ocu", int'(ocu_w), 0);
        verificar("rstmul_ovf", int'(ovf_s), 0);
        @(negedge clk);
        reset = 1'b0;
        vistos = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (exe_w || exe_s) vistos++;
        end
        verificar("rstmul_sem_exe", vistos, 0);
        enviar(OP_LOAD, 0, 5);
        verificar("load5_exe", int'(exe_w), 1);
        verificar("load5_res", s16(res_w), 5);

        // 6. invalid opcode holds state, then back-to-back single-cycle ops
        enviar(OP_ADD, 32767, 1);
        @(negedge clk);
        enviar(3'b111, 1, 2);
        verificar("inv_pulso", int'(inv_w), 1);
        verificar("inv_exe", int'(exe_w), 0);
        verificar("inv_res_w", s16(res_w), -32768);
        verificar("inv_res_s", s16(res_s), 32767);
        verificar("inv_ovf", int'(ovf_w), 1);
        verificar("inv_ocu", int'(ocu_w), 0);
        @(negedge clk);
        verificar("inv_fim", int'(inv_w), 0);
        enviar(OP_LOAD, 0, 3);
        verificar("b2b_load", s16(res_w), 3);
        verificar("b2b_load_ovf", int'(ovf_w), 0);
        enviar(OP_ADDI, 2, 2);
        verificar("b2b_add", s16(res_w), 4);
        verificar("b2b_add_exe", int'(exe_w), 1);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
